// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps a 4-input circuit through all patterns and checks its truth table
module truth_table_sweeper #(
  parameter logic [15:0] TRUTH_TABLE   = 16'hDA80,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLE_COUNT  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        drv_in1_o,
  output logic        drv_in2_o,
  output logic        drv_in3_o,
  output logic        drv_in4_o,
  input  logic        dut_out_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] captured_o,
  output logic [15:0] mismatch_o,
  output logic [3:0]  first_fail_o,
  output logic        fail_valid_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_RECORD = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_COUNT - 1);
  localparam logic [3:0] HALF_COUNT  = 4'(SAMPLE_COUNT / 2);

  logic [2:0]  state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  drv_q, drv_d;
  logic        sync1_q, sync2_q;
  logic [15:0] captured_q, captured_d;
  logic [15:0] mismatch_q, mismatch_d;
  logic [3:0]  first_fail_q, first_fail_d;
  logic        fail_valid_q, fail_valid_d;
  logic        pass_q, pass_d;

  logic vote;
  logic rec_mis;
  logic abortable;

  assign vote      = (ones_q > HALF_COUNT);
  assign rec_mis   = vote ^ TRUTH_TABLE[k_q];
  assign abortable = (state_q != S_IDLE) && (state_q != S_DONE);

  // Two-flop synchronizer for the asynchronous circuit output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= dut_out_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: sequencing, voting and result recording
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    ones_d       = ones_q;
    drv_d        = drv_q;
    captured_d   = captured_q;
    mismatch_d   = mismatch_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;

    if (abort_i && abortable) begin
      // Partial results are kept; the current pattern is not recorded.
      state_d = S_IDLE;
      drv_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            captured_d   = 16'd0;
            mismatch_d   = 16'd0;
            first_fail_d = 4'd0;
            fail_valid_d = 1'b0;
            pass_d       = 1'b0;
            k_d          = 4'd0;
            state_d      = S_APPLY;
          end
        end
        S_APPLY: begin
          drv_d   = k_q;
          cnt_d   = 8'd0;
          ones_d  = 4'd0;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          ones_d = ones_q + {3'd0, sync2_q};
          if (cnt_q == SAMPLE_LAST) begin
            state_d = S_RECORD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RECORD: begin
          captured_d[k_q] = vote;
          mismatch_d[k_q] = rec_mis;
          if (rec_mis && !fail_valid_q) begin
            first_fail_d = k_q;
            fail_valid_d = 1'b1;
          end
          if (k_q == 4'd15) begin
            // Computed here so pass is already valid during the done pulse.
            pass_d  = (mismatch_d == 16'd0);
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_APPLY;
          end
        end
        S_DONE: begin
          drv_d   = 4'd0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          drv_d   = 4'd0;
        end
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      k_q          <= 4'd0;
      cnt_q        <= 8'd0;
      ones_q       <= 4'd0;
      drv_q        <= 4'd0;
      captured_q   <= 16'd0;
      mismatch_q   <= 16'd0;
      first_fail_q <= 4'd0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      ones_q       <= ones_d;
      drv_q        <= drv_d;
      captured_q   <= captured_d;
      mismatch_q   <= mismatch_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
    end
  end

  assign drv_in1_o    = drv_q[3];
  assign drv_in2_o    = drv_q[2];
  assign drv_in3_o    = drv_q[1];
  assign drv_in4_o    = drv_q[0];
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign pass_o       = pass_q;
  assign captured_o   = captured_q;
  assign mismatch_o   = mismatch_q;
  assign first_fail_o = first_fail_q;
  assign fail_valid_o = fail_valid_q;

endmodule
